// File: rtl/sync_filter.sv
// sync_filter: multi-channel conditioner for asynchronous single-bit inputs.
// Each channel passes through a STAGES-deep synchroniser and a stable-count
// glitch filter, and produces registered one-cycle rise/fall pulses on the
// filtered level.
// Optional build macro SYNC_FILTER_EVT_EN adds sticky per-channel event flags
// (evt) with a per-channel clear (evt_clr).
module sync_filter #(
  parameter int unsigned      WIDTH         = 1,
  parameter int unsigned      STAGES        = 2,
  parameter int unsigned      FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
`ifdef SYNC_FILTER_EVT_EN
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] evt,
`endif
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned      CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject configurations the structure cannot honour.
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_filter: STAGES must be in 2..4");
  end
  if (WIDTH == 0 || WIDTH > 32) begin : g_bad_width
    $error("sync_filter: WIDTH must be in 1..32");
  end
  if (FILTER_CYCLES == 0 || FILTER_CYCLES > 65535) begin : g_bad_filter
    $error("sync_filter: FILTER_CYCLES must be in 1..65535");
  end

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]             sync_s;
  logic [WIDTH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]             out_q, out_d;
  logic [WIDTH-1:0]             rise_q, rise_d;
  logic [WIDTH-1:0]             fall_q, fall_d;

  // Synchroniser chain: raw input lands directly in stage 0, no logic ahead of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= in;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_s = sync_q[STAGES-1];

  // Per-channel stable-count filter; a pulse is produced on the same edge that updates out.
  always_comb begin
    out_d  = out_q;
    cnt_d  = cnt_q;
    rise_d = {WIDTH{1'b0}};
    fall_d = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_s[i] == out_q[i]) begin
        // Any return to the current level restarts the count.
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        out_d[i]  = sync_s[i];
        cnt_d[i]  = {CNT_W{1'b0}};
        rise_d[i] = sync_s[i];
        fall_d[i] = ~sync_s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Filter state and edge pulse registers; reset discards any partial count silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= RESET_VAL;
      cnt_q  <= {(WIDTH*CNT_W){1'b0}};
      rise_q <= {WIDTH{1'b0}};
      fall_q <= {WIDTH{1'b0}};
    end else begin
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef SYNC_FILTER_EVT_EN
  logic [WIDTH-1:0] evt_q, evt_d;

  // Sticky event flags: a pulse in the current cycle sets, clear only wins when idle.
  always_comb begin
    evt_d = rise_q | fall_q | (evt_q & ~evt_clr);
  end

  // Event flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_q <= {WIDTH{1'b0}};
    end else begin
      evt_q <= evt_d;
    end
  end

  assign evt = evt_q;
`endif

endmodule

// File: tb/tb_sync_filter.sv
// Self-checking bench for sync_filter: a default-parameter instance driven from
// a per-cycle vector table plus hand sequences, and a 4-channel instance
// (STAGES=3, FILTER_CYCLES=2) for channel independence.
module tb_sync_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:0] in1, out1, rise1, fall1;
  logic [3:0] in4, out4, rise4, fall4;
`ifdef SYNC_FILTER_EVT_EN
  logic [0:0] evt1, evt_clr1;
  logic [3:0] evt4, evt_clr4;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sync_filter u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in1),
`ifdef SYNC_FILTER_EVT_EN
    .evt_clr (evt_clr1),
    .evt     (evt1),
`endif
    .out     (out1),
    .rise    (rise1),
    .fall    (fall1)
  );

  sync_filter #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(2)) u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in4),
`ifdef SYNC_FILTER_EVT_EN
    .evt_clr (evt_clr4),
    .evt     (evt4),
`endif
    .out     (out4),
    .rise    (rise4),
    .fall    (fall4)
  );

  typedef struct {
    logic rst_n;
    logic in;
    logic exp_out;
    logic exp_rise;
    logic exp_fall;
  } vec_t;

  vec_t tbl[32];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in1   = 1'b1;
    in4   = 4'b0000;
`ifdef SYNC_FILTER_EVT_EN
    evt_clr1 = 1'b0;
    evt_clr4 = 4'b0000;
`endif

    // Vector table for the default instance (one entry per clock edge).
    // 0..2 reset with in=1; release at 3 -> out/rise at 8 (5 edges later).
    // 11..13 three-cycle low glitch: filtered out.
    // 20..23 four-cycle low: fall at 25; return high -> rise at 29.
    for (int i = 0; i < 32; i++) begin
      tbl[i].rst_n    = (i < 3) ? 1'b0 : 1'b1;
      tbl[i].in       = ((i >= 11 && i <= 13) || (i >= 20 && i <= 23)) ? 1'b0 : 1'b1;
      tbl[i].exp_out  = ((i >= 8 && i <= 24) || i >= 29) ? 1'b1 : 1'b0;
      tbl[i].exp_rise = (i == 8 || i == 29) ? 1'b1 : 1'b0;
      tbl[i].exp_fall = (i == 25) ? 1'b1 : 1'b0;
    end

    for (int i = 0; i < 32; i++) begin
      rst_n = tbl[i].rst_n;
      in1   = tbl[i].in;
      step();
      chk($sformatf("tbl[%0d].out", i),  {31'd0, out1},  {31'd0, tbl[i].exp_out});
      chk($sformatf("tbl[%0d].rise", i), {31'd0, rise1}, {31'd0, tbl[i].exp_rise});
      chk($sformatf("tbl[%0d].fall", i), {31'd0, fall1}, {31'd0, tbl[i].exp_fall});
    end

    // Toggle every 2 cycles for 40 cycles: out must stay 1 with no pulses.
    for (int c = 0; c < 40; c++) begin
      in1 = ((c / 2) % 2 == 1) ? 1'b1 : 1'b0;
      step();
      chk($sformatf("toggle[%0d].out", c), {31'd0, out1}, 32'd1);
      chk($sformatf("toggle[%0d].edge", c), {30'd0, rise1, fall1}, 32'd0);
    end
    in1 = 1'b1;
    step();
    step();

    // Reset mid-filter: bring out to 0 first.
    rst_n = 1'b0;
    in1   = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("pre_mid.out", {31'd0, out1}, 32'd0);
    in1 = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mid_rst[%0d].out", k), {31'd0, out1}, 32'd0);
      chk($sformatf("mid_rst[%0d].rise", k), {31'd0, rise1}, 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("post_rst[%0d].out", k), {31'd0, out1}, (k >= 5) ? 32'd1 : 32'd0);
      chk($sformatf("post_rst[%0d].rise", k), {31'd0, rise1}, (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("post_rst[%0d].fall", k), {31'd0, fall1}, 32'd0);
    end

`ifdef SYNC_FILTER_EVT_EN
    // Rise at k=5 above sets evt on the following edge; it must hold.
    chk("evt.set", {31'd0, evt1}, 32'd1);
    step();
    step();
    chk("evt.hold", {31'd0, evt1}, 32'd1);
    evt_clr1 = 1'b1;
    step();
    evt_clr1 = 1'b0;
    chk("evt.clr", {31'd0, evt1}, 32'd0);
    in1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("evt_fall[%0d].out", k), {31'd0, out1}, (k >= 5) ? 32'd0 : 32'd1);
      chk($sformatf("evt_fall[%0d].fall", k), {31'd0, fall1}, (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("evt_fall[%0d].evt", k), {31'd0, evt1}, 32'd0);
    end
    // Clear requested in the same cycle the fall pulse is high: set wins.
    evt_clr1 = 1'b1;
    step();
    evt_clr1 = 1'b0;
    chk("evt.set_wins", {31'd0, evt1}, 32'd1);
    chk("evt.fall_done", {31'd0, fall1}, 32'd0);
`endif

    // Four-channel instance: step 0000 -> 1010, latency 3+2-1 = 4 edges.
    in4 = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("w4a[%0d].out", k),  {28'd0, out4},  (k >= 4) ? 32'hA : 32'h0);
      chk($sformatf("w4a[%0d].rise", k), {28'd0, rise4}, (k == 4) ? 32'hA : 32'h0);
      chk($sformatf("w4a[%0d].fall", k), {28'd0, fall4}, 32'h0);
    end
    // 1010 -> 0011: ch0 rises, ch3 falls together; ch1/ch2 unchanged.
    in4 = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("w4b[%0d].out", k),  {28'd0, out4},  (k >= 4) ? 32'h3 : 32'hA);
      chk($sformatf("w4b[%0d].rise", k), {28'd0, rise4}, (k == 4) ? 32'h1 : 32'h0);
      chk($sformatf("w4b[%0d].fall", k), {28'd0, fall4}, (k == 4) ? 32'h8 : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
